// File: rtl/handshake_stream_driver_if.sv
// Ready/valid stream bundle: the source owns valid and data, the sink owns ready.
interface handshake_stream_driver_if #(
   parameter int WIDTH = 4
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/handshake_stream_driver.sv
// Ready/valid burst source: emits burst_len incrementing words from seed, with an
// optional fixed idle gap between beats, and pulses done after the last transfer.
module handshake_stream_driver #(
   parameter int WIDTH   = 4,
   parameter int COUNT_W = 8,
   parameter int GAP_W   = 4
) (
   input  logic                          CLK,
   input  logic                          ASYNCRESETN,
   input  logic                          start,
   input  logic [COUNT_W-1:0]            burst_len,
   input  logic [GAP_W-1:0]              gap,
   input  logic [WIDTH-1:0]              seed,
   handshake_stream_driver_if.master     hs,
   output logic                          busy,
   output logic                          done,
   output logic [COUNT_W-1:0]            sent_count
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t             state_reg, state_next;
   logic [COUNT_W-1:0] remaining_reg, remaining_next;
   logic [COUNT_W-1:0] count_reg, count_next;
   logic [GAP_W-1:0]   gap_len_reg, gap_len_next;
   logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
   logic [WIDTH-1:0]   data_reg, data_next;
   logic               valid_reg, valid_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               xfer;

   assign xfer = valid_reg && hs.out_ready;

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_reg     <= S_IDLE;
         remaining_reg <= '0;
         count_reg     <= '0;
         gap_len_reg   <= '0;
         gap_cnt_reg   <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         count_reg     <= count_next;
         gap_len_reg   <= gap_len_next;
         gap_cnt_reg   <= gap_cnt_next;
         data_reg      <= data_next;
         valid_reg     <= valid_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:
            if (start && burst_len != '0) state_next = S_SEND;
         S_SEND:
            if (xfer) begin
               if (remaining_reg == COUNT_W'(1)) state_next = S_DONE;
               else if (gap_len_reg != '0)       state_next = S_GAP;
            end
         S_GAP:
            if (gap_cnt_reg <= GAP_W'(1)) state_next = S_SEND;
         S_DONE:
            state_next = S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state so that every port comes straight off a flop.
   always_comb begin
      remaining_next = remaining_reg;
      count_next     = count_reg;
      gap_len_next   = gap_len_reg;
      gap_cnt_next   = gap_cnt_reg;
      data_next      = data_reg;
      case (state_reg)
         S_IDLE:
            if (start && burst_len != '0) begin
               remaining_next = burst_len;
               gap_len_next   = gap;
               data_next      = seed;
            end
         S_SEND:
            if (xfer) begin
               remaining_next = remaining_reg - COUNT_W'(1);
               count_next     = count_reg + COUNT_W'(1);
               data_next      = data_reg + WIDTH'(1);
               gap_cnt_next   = gap_len_reg;
            end
         S_GAP:
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
         default: ;
      endcase
      valid_next = (state_next == S_SEND);
      busy_next  = (state_next == S_SEND) || (state_next == S_GAP);
      done_next  = (state_next == S_DONE) ||
                   (state_reg == S_IDLE && start && burst_len == '0);
   end

   assign hs.out_valid = valid_reg;
   assign hs.out_data  = data_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign sent_count   = count_reg;

endmodule

// File: tb/tb_handshake_stream_driver.sv
// Randomised bench for handshake_stream_driver: a burst-level model predicts payloads,
// gap lengths, done timing and the running transfer count.
module tb_handshake_stream_driver;
   localparam int WIDTH   = 4;
   localparam int COUNT_W = 8;
   localparam int GAP_W   = 4;

   logic               CLK = 1'b0;
   logic               ASYNCRESETN = 1'b0;
   logic               start = 1'b0;
   logic [COUNT_W-1:0] burst_len = '0;
   logic [GAP_W-1:0]   gap = '0;
   logic [WIDTH-1:0]   seed = '0;
   logic               busy, done;
   logic [COUNT_W-1:0] sent_count;

   int tests = 0;
   int fails = 0;
   logic [COUNT_W-1:0] model_count = '0;

   handshake_stream_driver_if #(.WIDTH(WIDTH)) hs ();

   handshake_stream_driver #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .GAP_W(GAP_W)) dut (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .start(start), .burst_len(burst_len),
      .gap(gap), .seed(seed), .hs(hs), .busy(busy), .done(done), .sent_count(sent_count)
   );

   always #5 CLK = ~CLK;

   // mode 0: ready tied high, 1: random ready, 2: ready low for first 5 valid cycles
   task automatic run_burst(input int len, input int g, input logic [WIDTH-1:0] s,
                            input int mode, input bit hold_start);
      int k = 0, cyc = 0, idle = 0, stall = 0, first_v = -1, last_x = -1;
      int budget;
      bit after_xfer = 0, done_seen = 0, prev_v = 0, prev_r = 0;
      logic [WIDTH-1:0] prev_d = '0, exp_d;
      budget = 4 * (len + 1) * (g + 1) + 50;
      start = 1'b1; burst_len = COUNT_W'(len); gap = GAP_W'(g); seed = s;
      hs.out_ready = 1'b1;
      @(negedge CLK);
      if (!hold_start) start = 1'b0;
      while (!done_seen && cyc < budget) begin
         if (k == len) begin
            tests++;
            if (done !== 1'b1 || busy !== 1'b0 || hs.out_valid !== 1'b0) begin
               fails++;
               $display("FAIL done_cycle: done=%b busy=%b valid=%b, required 1 0 0", done, busy, hs.out_valid);
            end
            tests++;
            if (sent_count !== model_count) begin
               fails++;
               $display("FAIL sent_count: got %0d, required %0d", sent_count, model_count);
            end
            done_seen = 1;
         end else begin
            tests++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               fails++;
               $display("FAIL busy_mid_burst: done=%b busy=%b, required 0 1", done, busy);
            end
            if (prev_v && !prev_r) begin
               tests++;
               if (hs.out_valid !== 1'b1 || hs.out_data !== prev_d) begin
                  fails++;
                  $display("FAIL stall_hold: valid=%b data=%h, required 1 %h", hs.out_valid, hs.out_data, prev_d);
               end
            end
            if (hs.out_valid === 1'b1) begin
               if (first_v < 0) first_v = cyc;
               exp_d = s + WIDTH'(k);
               tests++;
               if (hs.out_data !== exp_d) begin
                  fails++;
                  $display("FAIL beat_data: beat %0d got %h, required %h", k, hs.out_data, exp_d);
               end
               if (after_xfer) begin
                  tests++;
                  if (idle != g) begin
                     fails++;
                     $display("FAIL gap_len: got %0d idle cycles, required %0d", idle, g);
                  end
                  after_xfer = 0;
               end
            end else if (after_xfer) begin
               idle++;
            end
            case (mode)
               0: hs.out_ready = 1'b1;
               1: hs.out_ready = 1'($urandom_range(0, 1));
               default: begin
                  hs.out_ready = (stall >= 5);
                  if (hs.out_valid === 1'b1 && stall < 5) stall++;
               end
            endcase
            if (hs.out_valid === 1'b1 && hs.out_ready) begin
               k++;
               model_count = model_count + COUNT_W'(1);
               after_xfer = 1;
               idle = 0;
               last_x = cyc;
            end
         end
         prev_v = (hs.out_valid === 1'b1);
         prev_r = hs.out_ready;
         prev_d = hs.out_data;
         if (!done_seen) begin
            cyc++;
            @(negedge CLK);
         end
      end
      if (!done_seen) begin
         tests++; fails++;
         $display("FAIL burst_timeout: %0d of %0d beats after %0d cycles", k, len, cyc);
      end
      if (mode == 0 && len > 0) begin
         tests++;
         if (last_x - first_v + 1 != len + (len - 1) * g) begin
            fails++;
            $display("FAIL burst_latency: got %0d cycles, required %0d", last_x - first_v + 1, len + (len - 1) * g);
         end
      end
      @(negedge CLK);
      tests++;
      if (done !== 1'b0 || hs.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL done_single_pulse: done=%b valid=%b, required 0 0", done, hs.out_valid);
      end
      $display("[TB] burst len=%0d gap=%0d seed=%h mode=%0d beats=%0d sent_count=%0d", len, g, s, mode, k, sent_count);
   endtask

   task automatic test_reset();
      @(negedge CLK);
      tests++;
      if (hs.out_valid !== 1'b0 || hs.out_data !== '0 || busy !== 1'b0 || done !== 1'b0 || sent_count !== '0) begin
         fails++;
         $display("FAIL reset_state: valid=%b data=%h busy=%b done=%b count=%0d, required all 0",
                  hs.out_valid, hs.out_data, busy, done, sent_count);
      end
      ASYNCRESETN = 1'b1;
      @(negedge CLK);
      tests++;
      if (hs.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_reset: valid=%b busy=%b done=%b, required 0 0 0", hs.out_valid, busy, done);
      end
   endtask

   task automatic test_full_rate();     run_burst(4, 0, 4'hE, 0, 0); endtask
   task automatic test_gap();           run_burst(3, 2, 4'h5, 0, 0); endtask
   task automatic test_stall();         run_burst(2, 0, 4'h9, 2, 0); endtask
   task automatic test_zero_len();      run_burst(0, 1, 4'h7, 0, 0); endtask

   task automatic test_async_reset();
      start = 1'b1; burst_len = 8'd4; gap = '0; seed = 4'h3; hs.out_ready = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      @(negedge CLK);
      tests++;
      if (sent_count !== model_count + COUNT_W'(1)) begin
         fails++;
         $display("FAIL pre_reset_count: got %0d, required %0d", sent_count, model_count + COUNT_W'(1));
      end
      #2 ASYNCRESETN = 1'b0;
      #1;
      tests++;
      if (hs.out_valid !== 1'b0 || busy !== 1'b0 || sent_count !== '0 || done !== 1'b0) begin
         fails++;
         $display("FAIL async_abort: valid=%b busy=%b count=%0d done=%b, required 0 0 0 0",
                  hs.out_valid, busy, sent_count, done);
      end
      model_count = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         tests++;
         if (done !== 1'b0 || hs.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL no_done_in_reset: done=%b valid=%b, required 0 0", done, hs.out_valid);
         end
      end
      ASYNCRESETN = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_start_held();
      run_burst(2, 0, 4'hA, 0, 1);
      run_burst(2, 0, 4'hC, 0, 0);
      tests++;
      if (sent_count !== model_count) begin
         fails++;
         $display("FAIL start_held_count: got %0d, required %0d", sent_count, model_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++)
         run_burst(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                   WIDTH'($urandom), int'($urandom_range(0, 1)), 0);
      // long burst carries the transfer counter through its wrap
      run_burst(250, 0, WIDTH'($urandom), 1, 0);
   endtask

   initial begin
      hs.out_ready = 1'b1;
      test_reset();
      test_full_rate();
      test_gap();
      test_stall();
      test_zero_len();
      test_async_reset();
      test_start_held();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
